// File: rtl/mb_pkg.sv
// Shared Modified Booth (radix-4) definitions used by the encoder and decoder sides.
//   mb_state_t      : serial decoder FSM states
//   DIGIT_ZERO      : {one,two} encoding of a zero-magnitude digit
//   DIGIT_ILLEGAL   : {one,two} encoding that is not a legal MB digit
//   idx_w / data_w  : width helpers derived from the digit count
package mb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mb_state_t;

  localparam logic [1:0] DIGIT_ZERO    = 2'b00;
  localparam logic [1:0] DIGIT_ILLEGAL = 2'b11;

  // Digit index counter width; a single-digit vector still needs one bit.
  function automatic int idx_w(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  function automatic int data_w(input int digits);
    return 2 * digits;
  endfunction

endpackage

// File: rtl/mb_digit_decode.sv
// Combinational decode of one MB digit.
//   sign    in   1  digit is negative
//   one     in   1  magnitude 1
//   two     in   1  magnitude 2
//   val     out  3  signed digit value in [-2, 2]
//   illegal out  1  one and two both set; val forced to 0
module mb_digit_decode
  import mb_pkg::*;
(
  input  logic              sign,
  input  logic              one,
  input  logic              two,
  output logic signed [2:0] val,
  output logic              illegal
);

  always_comb begin
    val     = 3'sd0;
    illegal = 1'b0;
    case ({one, two})
      DIGIT_ZERO:    val = 3'sd0;            // negative zero is still zero
      2'b10:         val = sign ? -3'sd1 : 3'sd1;
      2'b01:         val = sign ? -3'sd2 : 3'sd2;
      DIGIT_ILLEGAL: illegal = 1'b1;
      default:       val = 3'sd0;
    endcase
  end

endmodule

// File: rtl/mb_serial_decoder.sv
// Serial MB -> two's-complement decoder. Captures one digit vector, folds it in
// MSB digit first with Horner's rule (acc = 4*acc + d), then offers the result.
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          digit vector handshake (ready only when idle)
//   in_sign/in_one/in_two      per-digit fields, bit i = digit i
//   out_valid/out_ready        result handshake
//   out_data                   low DATA_W bits of the sum
//   out_ovf                    sum outside the DATA_W signed range
//   out_err                    at least one illegal digit seen
module mb_serial_decoder
  import mb_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int DATA_W = data_w(DIGITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIGITS-1:0] in_sign,
  input  logic [DIGITS-1:0] in_one,
  input  logic [DIGITS-1:0] in_two,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  output logic              out_err
);

  localparam int IDX_W = idx_w(DIGITS);
  // Two guard bits hold any sum of DIGITS digits, so overflow is a plain range test.
  localparam int ACC_W = DATA_W + 2;
  localparam logic signed [ACC_W-1:0] OVF_HI = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] OVF_LO = ~OVF_HI;

  mb_state_t                  state, state_nxt;
  logic [DIGITS-1:0]          sign_q, one_q, two_q;
  logic [IDX_W-1:0]           idx;
  logic signed [ACC_W-1:0]    acc, acc_nxt, dext;
  logic                       err;

  logic [DIGITS-1:0][2:0]     dval;
  logic [DIGITS-1:0]          dill;
  logic [2:0]                 dsel;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    mb_digit_decode u_dec (
      .sign    (sign_q[g]),
      .one     (one_q[g]),
      .two     (two_q[g]),
      .val     (dval[g]),
      .illegal (dill[g])
    );
  end

  assign dsel     = dval[idx];
  assign dext     = {{(ACC_W-3){dsel[2]}}, dsel};
  assign acc_nxt  = (acc <<< 2) + dext;
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)             state_nxt = RUN;
      RUN:     if (idx == '0)            state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q    <= '0;
      one_q     <= '0;
      two_q     <= '0;
      idx       <= '0;
      acc       <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_q <= in_sign;
          one_q  <= in_one;
          two_q  <= in_two;
          acc    <= '0;
          idx    <= IDX_W'(DIGITS-1);
          err    <= 1'b0;
        end
        RUN: begin
          acc <= acc_nxt;
          err <= err | dill[idx];
          if (idx != '0) idx <= idx - 1'b1;
        end
        DONE: begin
          // First DONE cycle registers the result; it then holds until taken.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= acc[DATA_W-1:0];
            out_ovf   <= (acc > OVF_HI) || (acc < OVF_LO);
            out_err   <= err;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mb_serial_decoder.sv
module tb_mb_serial_decoder;
  localparam int DIGITS = 4;
  localparam int DATA_W = 2 * DIGITS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DIGITS-1:0] in_sign = '0, in_one = '0, in_two = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_ovf, out_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mb_serial_decoder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_one    (in_one),
    .in_two    (in_two),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_err   (out_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Present a vector for one edge, then scramble the inputs to prove capture.
  task automatic send(input logic [3:0] s, input logic [3:0] o, input logic [3:0] t);
    in_sign = s; in_one = o; in_two = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sign = ~s; in_one = ~o; in_two = t ^ o;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [3:0] s, input logic [3:0] o,
                         input logic [3:0] t, input logic [7:0] ed, input logic eo,
                         input logic ee);
    int n;
    chk({tag, ".rdy"}, in_ready, 1);
    send(s, o, t);
    chk({tag, ".busy"}, in_ready, 0);
    wait_out(n);
    chk({tag, ".lat"}, n, DIGITS + 1);
    chk({tag, ".data"}, out_data, ed);
    chk({tag, ".ovf"}, out_ovf, eo);
    chk({tag, ".err"}, out_err, ee);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".vld0"}, out_valid, 0);
    chk({tag, ".rdy1"}, in_ready, 1);
  endtask

  initial begin
    int n;
    #1;
    chk("rst.rdy", in_ready, 1);
    chk("rst.vld", out_valid, 0);
    chk("rst.data", out_data, 0);
    chk("rst.ovf", out_ovf, 0);
    chk("rst.err", out_err, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // digits +2,-1,-1,-1 -> 107
    run_vec("t1", 4'b0111, 4'b0111, 4'b1000, 8'h6B, 1'b0, 1'b0);
    // -2 in top digit -> -128, exactly the lower bound
    run_vec("t2", 4'b1000, 4'b0000, 4'b1000, 8'h80, 1'b0, 1'b0);
    // all +2 -> 170
    run_vec("t3", 4'b0000, 4'b0000, 4'b1111, 8'hAA, 1'b1, 1'b0);
    // illegal digit 1
    run_vec("t4a", 4'b0010, 4'b0010, 4'b0010, 8'h00, 1'b0, 1'b1);
    // negative zeros
    run_vec("t4b", 4'b1111, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0);
    // all -2 -> -170 = 0x56 mod 256
    run_vec("tneg2", 4'b1111, 4'b0000, 4'b1111, 8'h56, 1'b1, 1'b0);
    // all -1 -> -85
    run_vec("tneg1", 4'b1111, 4'b1111, 4'b0000, 8'hAB, 1'b0, 1'b0);

    // Back-pressure: +2,+1,+2,+1 -> 153
    send(4'b0000, 4'b0101, 4'b1010);
    wait_out(n);
    chk("t5.lat", n, DIGITS + 1);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_sign = 4'(k); in_one = 4'b1111; in_two = 4'b0000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("t5.vld", out_valid, 1);
      chk("t5.data", out_data, 8'h99);
      chk("t5.ovf", out_ovf, 1);
      chk("t5.err", out_err, 0);
      chk("t5.busy", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t5.vld0", out_valid, 0);
    chk("t5.rdy1", in_ready, 1);
    run_vec("t5b", 4'b0111, 4'b0111, 4'b1000, 8'h6B, 1'b0, 1'b0);

    // Reset during second RUN cycle
    send(4'b1000, 4'b0000, 4'b1000);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6.rdy", in_ready, 1);
    chk("t6.vld", out_valid, 0);
    chk("t6.data", out_data, 0);
    chk("t6.ovf", out_ovf, 0);
    chk("t6.err", out_err, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("t6.stale", out_valid, 0);
    run_vec("t6b", 4'b0000, 4'b0000, 4'b1111, 8'hAA, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
